// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FPU issue arbiter and its response path.
package fpu_ctrl_pkg;

   typedef enum logic [2:0] {
      FOP_ADD = 3'd0,
      FOP_SUB = 3'd1,
      FOP_MUL = 3'd2,
      FOP_DIV = 3'd3
   } fpu_op_e;

   localparam int FLAGS_W  = 6;
   localparam int FLG_INF  = 5;
   localparam int FLG_IND  = 4;
   localparam int FLG_QNAN = 3;
   localparam int FLG_SNAN = 2;
   localparam int FLG_OVF  = 1;
   localparam int FLG_UNF  = 0;

   localparam logic [FLAGS_W-1:0] FLG_ALL = FLAGS_W'((1 << FLG_INF) | (1 << FLG_IND) |
                                                     (1 << FLG_QNAN) | (1 << FLG_SNAN) |
                                                     (1 << FLG_OVF) | (1 << FLG_UNF));

   // op is kept as raw bits so codes 4-7 pass through untouched.
   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] opa;
      logic [31:0] opb;
      logic [1:0]  rmode;
   } fpu_req_t;

   typedef struct packed {
      logic               id;
      logic [31:0]        result;
      logic [FLAGS_W-1:0] flags;
   } rsp_entry_t;

endpackage

// File: rtl/fpu_issue_arb_if.sv
// Request, core-issue, response and status signals of the FPU issue arbiter.
interface fpu_issue_arb_if;
   import fpu_ctrl_pkg::*;

   logic               req0_valid;
   logic               req0_ready;
   logic [2:0]         req0_op;
   logic [31:0]        req0_opa;
   logic [31:0]        req0_opb;
   logic [1:0]         req0_rmode;

   logic               req1_valid;
   logic               req1_ready;
   logic [2:0]         req1_op;
   logic [31:0]        req1_opa;
   logic [31:0]        req1_opb;
   logic [1:0]         req1_rmode;

   logic               fpu_start;
   logic [2:0]         fpu_op;
   logic [31:0]        fpu_opa;
   logic [31:0]        fpu_opb;
   logic [1:0]         fpu_rmode;
   logic [31:0]        fpu_out;
   logic [FLAGS_W-1:0] fpu_flags;

   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [31:0]        rsp_result;
   logic [FLAGS_W-1:0] rsp_flags;

   logic [FLAGS_W-1:0] sticky0;
   logic [FLAGS_W-1:0] sticky1;
   logic               clr_sticky0;
   logic               clr_sticky1;
   logic               busy;

   modport slave (
      input  req0_valid, req0_op, req0_opa, req0_opb, req0_rmode,
      output req0_ready,
      input  req1_valid, req1_op, req1_opa, req1_opb, req1_rmode,
      output req1_ready,
      output fpu_start, fpu_op, fpu_opa, fpu_opb, fpu_rmode,
      input  fpu_out, fpu_flags,
      output rsp_valid, rsp_id, rsp_result, rsp_flags,
      input  rsp_ready,
      output sticky0, sticky1, busy,
      input  clr_sticky0, clr_sticky1
   );

   modport master (
      output req0_valid, req0_op, req0_opa, req0_opb, req0_rmode,
      input  req0_ready,
      output req1_valid, req1_op, req1_opa, req1_opb, req1_rmode,
      input  req1_ready,
      input  fpu_start, fpu_op, fpu_opa, fpu_opb, fpu_rmode,
      output fpu_out, fpu_flags,
      input  rsp_valid, rsp_id, rsp_result, rsp_flags,
      output rsp_ready,
      input  sticky0, sticky1, busy,
      output clr_sticky0, clr_sticky1
   );

endinterface

// File: rtl/fpu_res_fifo.sv
// Synchronous response FIFO; head is read combinationally, a write into an
// empty FIFO becomes visible on the following cycle.
module fpu_res_fifo
   import fpu_ctrl_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_wr,
   input  rsp_entry_t i_wr_data,
   input  logic       i_rd,
   output rsp_entry_t o_rd_data,
   output logic       o_full,
   output logic       o_empty,
   output logic [CW-1:0] o_count
);

   rsp_entry_t    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_wr;
   logic          w_do_rd;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   // A simultaneous pop frees the slot, so a write is legal even when full.
   assign w_do_rd = i_rd && !o_empty;
   assign w_do_wr = i_wr && (!o_full || w_do_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

endmodule

// File: rtl/fpu_issue_arb.sv
// Round-robin issue arbiter sharing one fixed-latency FPU core between two
// requesters, with in-order response buffering and per-requester sticky flags.
module fpu_issue_arb
   import fpu_ctrl_pkg::*;
#(
   parameter int PIPE_LAT  = 4,
   parameter int RES_DEPTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   fpu_issue_arb_if.slave bus
);

   localparam int OCC_W = $clog2(RES_DEPTH + 1);

   logic [OCC_W-1:0]    r_occ;
   logic                r_last_id;
   logic                w_credit;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                w_acc;
   logic                w_acc_id;
   logic                w_pop;
   fpu_req_t            w_req0;
   fpu_req_t            w_req1;
   fpu_req_t            w_sel_req;

   logic                r_start_p0;
   logic                r_id_p0;
   fpu_req_t            r_req_p0;

   logic [PIPE_LAT-1:0] r_tag_vld_p1;
   logic [PIPE_LAT-1:0] r_tag_id_p1;

   logic                w_wr;
   logic                w_fifo_wr;
   logic                w_full;
   logic                w_empty;
   logic [OCC_W-1:0]    w_count;
   rsp_entry_t          w_wr_entry;
   rsp_entry_t          w_head;
   logic [FLAGS_W-1:0]  r_sticky0;
   logic [FLAGS_W-1:0]  r_sticky1;

   // A clear in the same cycle as a write keeps only the new flags.
   function automatic logic [FLAGS_W-1:0] sticky_next(input logic [FLAGS_W-1:0] cur,
                                                      input logic               set,
                                                      input logic [FLAGS_W-1:0] flags,
                                                      input logic               clr);
      if (clr) return set ? flags : '0;
      return set ? (cur | flags) : cur;
   endfunction

   always_comb begin
      w_req0    = '{op: bus.req0_op, opa: bus.req0_opa, opb: bus.req0_opb, rmode: bus.req0_rmode};
      w_req1    = '{op: bus.req1_op, opa: bus.req1_opa, opb: bus.req1_opb, rmode: bus.req1_rmode};
      w_credit  = (r_occ < OCC_W'(RES_DEPTH));
      w_gnt0    = w_credit && bus.req0_valid && (!bus.req1_valid || r_last_id);
      w_gnt1    = w_credit && bus.req1_valid && (!bus.req0_valid || !r_last_id);
      w_acc     = w_gnt0 || w_gnt1;
      w_acc_id  = w_gnt1;
      w_sel_req = w_gnt1 ? w_req1 : w_req0;
      w_pop     = !w_empty && bus.rsp_ready;
   end

   assign bus.req0_ready = w_gnt0;
   assign bus.req1_ready = w_gnt1;

   // Occupancy spans issue register, tag pipe and FIFO; it is the credit pool.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_occ     <= '0;
         r_last_id <= 1'b1;
      end else begin
         case ({w_acc, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
         if (w_acc) r_last_id <= w_acc_id;
      end
   end

   // Stage p0: issue register driving the core port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_start_p0 <= 1'b0;
         r_id_p0    <= 1'b0;
         r_req_p0   <= '0;
      end else begin
         r_start_p0 <= w_acc;
         if (w_acc) begin
            r_req_p0 <= w_sel_req;
            r_id_p0  <= w_acc_id;
         end
      end
   end

   assign bus.fpu_start = r_start_p0;
   assign bus.fpu_op    = r_req_p0.op;
   assign bus.fpu_opa   = r_req_p0.opa;
   assign bus.fpu_opb   = r_req_p0.opb;
   assign bus.fpu_rmode = r_req_p0.rmode;

   // Stage p1..: tag pipe; the last stage lines up with the core output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_vld_p1 <= '0;
      end else begin
         r_tag_vld_p1[0] <= r_start_p0;
         for (int i = 1; i < PIPE_LAT; i++) r_tag_vld_p1[i] <= r_tag_vld_p1[i-1];
      end
   end

   always_ff @(posedge clk) begin
      r_tag_id_p1[0] <= r_id_p0;
      for (int i = 1; i < PIPE_LAT; i++) r_tag_id_p1[i] <= r_tag_id_p1[i-1];
   end

   assign w_wr       = r_tag_vld_p1[PIPE_LAT-1];
   assign w_fifo_wr  = w_wr && (!w_full || w_pop);
   assign w_wr_entry = '{id: r_tag_id_p1[PIPE_LAT-1], result: bus.fpu_out,
                         flags: bus.fpu_flags & FLG_ALL};

   fpu_res_fifo #(.DEPTH(RES_DEPTH)) u_res_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr      (w_fifo_wr),
      .i_wr_data (w_wr_entry),
      .i_rd      (w_pop),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   assign bus.rsp_valid  = !w_empty;
   assign bus.rsp_id     = w_head.id;
   assign bus.rsp_result = w_head.result;
   assign bus.rsp_flags  = w_head.flags;

   // Stage p2: sticky flags accumulate at FIFO write time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky0 <= '0;
         r_sticky1 <= '0;
      end else begin
         r_sticky0 <= sticky_next(r_sticky0, w_fifo_wr && !w_wr_entry.id, w_wr_entry.flags,
                                  bus.clr_sticky0);
         r_sticky1 <= sticky_next(r_sticky1, w_fifo_wr && w_wr_entry.id, w_wr_entry.flags,
                                  bus.clr_sticky1);
      end
   end

   assign bus.sticky0 = r_sticky0;
   assign bus.sticky1 = r_sticky1;
   assign bus.busy    = (r_occ != '0);

   a_fifo_within_occ: assert property (@(posedge clk) disable iff (!rst_n) w_count <= r_occ);

endmodule
